zind_seq: RTL and testbench
===========================

Name: zind_seq

Overview:
Sequencer for the convolution z-index datapath.
- On a start command it walks the output index z from 0 to zlen-1, where zlen = sizex + sizey - 1.
- For each z it issues a compute request to the MAC datapath, waits for its acknowledge, then pulses a result-write strobe.
- It sits between the core's configuration/start registers and the MAC/memory-write logic, and owns the only copy of the running z index.

Parameters:
ZW, 6, z-index and size width in bits; maximum zlen is 2^ZW = 64.

Ports:
clk  in  1  system clock, rising edge
rst_a  in  1  asynchronous active-high reset
start_i  in  1  single-cycle start request; sampled only in IDLE
abort_i  in  1  synchronous abort; honoured in every state except IDLE
sizex_i  in  ZW  length of x sequence; captured at start
sizey_i  in  ZW  length of y sequence; captured at start
calc_req_o  out  1  compute request to MAC datapath for zind_o
calc_ack_i  in  1  MAC datapath completion for the current z
zind_o  out  ZW  current z index, stable while calc_req_o or wr_en_o is high
wr_en_o  out  1  one-cycle result write strobe for zind_o
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when a run ends, normal or error
err_o  out  1  sticky configuration error flag; cleared by next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_a is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, captured sizes 0.
- States: IDLE, LOAD, REQ, WAIT, WRITE, DONE.
- IDLE:
  - start_i=1 -> capture sizex_i/sizey_i, clear err_o, go to LOAD.
  - Otherwise stay in IDLE. abort_i is ignored here.
- LOAD:
  - Compute zlen = sizex + sizey - 1 at ZW+1 bits.
  - If sizex==0 or sizey==0 or zlen > 2^ZW: set err_o, go to DONE.
  - Otherwise zind_o <= 0, go to REQ.
- REQ: calc_req_o=1 (registered). Next cycle go to WAIT.
- WAIT:
  - calc_req_o held at 1 until calc_ack_i=1.
  - On ack: drop calc_req_o, go to WRITE.
  - calc_ack_i is sampled only in WAIT; ack in any other state is ignored.
- WRITE:
  - wr_en_o=1 for exactly this cycle.
  - If zind_o == zlen-1, go to DONE.
  - Else zind_o <= zind_o + 1 (ZW-bit increment), go to REQ.
- DONE:
  - done_o=1 for one cycle, then go to IDLE.
  - zind_o keeps its last value until the next start.
- Latency:
  - start to first calc_req_o: 2 cycles.
  - Each z costs 3 + (ack delay) cycles. The minimum is 3 cycles per z, with ack in the first WAIT cycle.
  - Last WRITE to done_o: 1 cycle.
- Boundary cases:
  - zlen == 2^ZW (e.g. 32+33-1 = 64): the final z is 63, the run terminates in WRITE and the index never wraps.
  - zlen == 1 (sizex=sizey=1): one REQ/WAIT/WRITE, then DONE.
  - start_i while busy_o=1 is ignored, with no capture and no restart.
  - abort_i while busy_o=1: next state IDLE; calc_req_o and wr_en_o drop next edge; done_o not pulsed; zind_o cleared to 0. abort_i has priority over calc_ack_i and start_i.
  - calc_ack_i and abort_i together in WAIT: abort wins and wr_en_o is not asserted.
  - rst_a mid-run: immediate return to reset values, independent of clk.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE..DONE)
  - ZW default
  - ZMAX = 2^ZW constant used in the LOAD check
- No sub-module: the FSM, size registers, zlen adder and z incrementer fit in one module of about 150-200 lines.

Test Plan:
1. Reset then sizex=3, sizey=2, start_i pulse, ack 1 cycle after each request -> zind_o sequence 0,1,2,3 with four wr_en_o pulses, then done_o; err_o=0.
2. sizex=32, sizey=33, immediate ack -> 64 writes, last zind_o=63, done_o with no wrap to 0 and no 65th write.
3. sizex=0, sizey=5 -> no calc_req_o, err_o=1, done_o 2 cycles after start; a next valid start clears err_o.
4. Ack delayed 7 cycles on z=1 -> calc_req_o held high for all 8 WAIT cycles, zind_o stable at 1, a single wr_en_o follows.
5. abort_i asserted in WAIT at z=2 together with calc_ack_i -> no wr_en_o, no done_o; next cycle busy_o=0 and zind_o=0.
6. start_i pulsed mid-run, and rst_a asserted between clock edges mid-run -> start ignored with sizes unchanged; reset drives all outputs to 0 immediately.

Source files
------------

// File: rtl/zind_seq_pkg.sv
// Shared definitions for the convolution z-index sequencer.
// Holds the state encoding, the default index width and the largest
// legal output length (2^ZW) that LOAD checks the configuration against.
package zind_seq_pkg;

  localparam int ZW_DEFAULT = 6;

  // Number of distinct z values a ZW-bit index can address.
  function automatic int zMaxOf(input int zw);
    return 1 << zw;
  endfunction

  localparam int ZMAX = zMaxOf(ZW_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } zindState_e;

endpackage

// File: rtl/zind_seq.sv
// zind_seq: walks the output index z from 0 to sizex+sizey-2. For each z it
// raises a compute request to the MAC datapath, waits for the acknowledge,
// then pulses a one-cycle result-write strobe. It owns the only copy of the
// running z index.
//
// Ports:
//   clk         system clock, rising edge
//   rst_a       asynchronous active-high reset
//   start_i     single-cycle start request, sampled only while idle
//   abort_i     synchronous abort, honoured whenever busy
//   sizex_i     x sequence length, captured at start
//   sizey_i     y sequence length, captured at start
//   calc_req_o  compute request for zind_o, held until acknowledged
//   calc_ack_i  MAC completion for the current z, sampled only in WAIT
//   zind_o      current z index
//   wr_en_o     one-cycle result write strobe for zind_o
//   busy_o      high whenever the sequencer is not idle
//   done_o      one-cycle pulse when a run ends (normal or error)
//   err_o       sticky configuration error, cleared by the next start
module zind_seq
  import zind_seq_pkg::*;
#(
  parameter int ZW = ZW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_a,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [ZW-1:0] sizex_i,
  input  logic [ZW-1:0] sizey_i,
  output logic          calc_req_o,
  input  logic          calc_ack_i,
  output logic [ZW-1:0] zind_o,
  output logic          wr_en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [ZW:0] ZLIMIT = (ZW+1)'(zMaxOf(ZW));

  zindState_e    state_q, state_d;
  logic [ZW-1:0] sizeX_q, sizeX_d;
  logic [ZW-1:0] sizeY_q, sizeY_d;
  logic [ZW-1:0] zind_q, zind_d;
  logic          err_q, err_d;
  logic          calcReq_q, calcReq_d;
  logic          wrEn_q, wrEn_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [ZW:0]   zLen;
  logic          isLast;
  logic          cfgBad;

  // The length is formed one bit wider than the index so that the largest
  // legal run (2^ZW entries) is representable and an oversize sum is visible.
  assign zLen   = {1'b0, sizeX_q} + {1'b0, sizeY_q} - (ZW+1)'(1);
  assign isLast = ({1'b0, zind_q} == (zLen - (ZW+1)'(1)));
  assign cfgBad = (sizeX_q == '0) || (sizeY_q == '0) || (zLen > ZLIMIT);

  // Next-state logic. The normal walk is decided first; an abort while busy
  // then overrides everything, so it beats both the acknowledge and start.
  // The output strobes are decoded from the next state so that they leave
  // the flops cleanly aligned with the state they belong to.
  always_comb begin
    state_d = state_q;
    sizeX_d = sizeX_q;
    sizeY_d = sizeY_q;
    zind_d  = zind_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sizeX_d = sizex_i;
          sizeY_d = sizey_i;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cfgBad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          zind_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (calc_ack_i) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (isLast) begin
          state_d = ST_DONE;
        end else begin
          zind_d  = zind_q + ZW'(1);
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      zind_d  = '0;
      err_d   = err_q;
    end

    calcReq_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
    wrEn_d    = (state_d == ST_WRITE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // State, captured configuration, index and registered output flops.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= ST_IDLE;
      sizeX_q   <= '0;
      sizeY_q   <= '0;
      zind_q    <= '0;
      err_q     <= 1'b0;
      calcReq_q <= 1'b0;
      wrEn_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sizeX_q   <= sizeX_d;
      sizeY_q   <= sizeY_d;
      zind_q    <= zind_d;
      err_q     <= err_d;
      calcReq_q <= calcReq_d;
      wrEn_q    <= wrEn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign calc_req_o = calcReq_q;
  assign zind_o     = zind_q;
  assign wr_en_o    = wrEn_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_zind_seq.sv
// Testbench for zind_seq. Each start pushes the expected write sequence
// (z value and request length) onto a scoreboard; a monitor pops and
// compares on every write strobe. An ack responder plays the MAC datapath.
module tb_zind_seq;

  localparam int ZW = 6;

  logic          clk;
  logic          rst_a;
  logic          start_i;
  logic          abort_i;
  logic [ZW-1:0] sizex_i;
  logic [ZW-1:0] sizey_i;
  logic          calc_req_o;
  logic          calc_ack_i;
  logic [ZW-1:0] zind_o;
  logic          wr_en_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  typedef struct {
    int z;
    int reqLen;
  } expWrite_t;

  expWrite_t sbQ[$];

  int checks = 0;
  int errors = 0;
  int expErr = 0;
  int slowZ = -1;
  int slowExtra = 0;
  int doneCount = 0;
  int totalReq = 0;
  int ackRun = 0;

  zind_seq #(.ZW(ZW)) dut (
    .clk(clk),
    .rst_a(rst_a),
    .start_i(start_i),
    .abort_i(abort_i),
    .sizex_i(sizex_i),
    .sizey_i(sizey_i),
    .calc_req_o(calc_req_o),
    .calc_ack_i(calc_ack_i),
    .zind_o(zind_o),
    .wr_en_o(wr_en_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // MAC stand-in: acknowledges in the first WAIT cycle unless the current z
  // is the designated slow one, which gets extra WAIT cycles.
  initial begin
    calc_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (calc_req_o) begin
        ackRun++;
        calc_ack_i = (ackRun >= 2 + ((int'(zind_o) == slowZ) ? slowExtra : 0));
      end else begin
        ackRun = 0;
        calc_ack_i = 1'b0;
      end
    end
  end

  // Monitor: tracks request bursts, checks z stays put while requested and
  // compares every write strobe against the scoreboard head.
  initial begin
    int reqRun;
    int lastReqRun;
    int reqZind;
    expWrite_t e;
    reqRun = 0;
    lastReqRun = 0;
    reqZind = 0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        reqRun = 0;
      end else begin
        if (calc_req_o) begin
          if (reqRun == 0) reqZind = int'(zind_o);
          else checkOutput("req_zind_stable", int'(zind_o), reqZind);
          reqRun++;
          totalReq++;
        end else begin
          if (reqRun != 0) lastReqRun = reqRun;
          reqRun = 0;
        end
        if (wr_en_o) begin
          if (sbQ.size() == 0) begin
            checkOutput("wr_unexpected", 1, 0);
          end else begin
            e = sbQ.pop_front();
            checkOutput("wr_zind", int'(zind_o), e.z);
            checkOutput("req_len", lastReqRun, e.reqLen);
          end
        end
        if (done_o) doneCount++;
      end
    end
  end

  // Issues a one-cycle start with the given sizes and pushes the writes a
  // correct sequencer must produce. Called and returns on a falling edge.
  task automatic applyStimulus(input int sx, input int sy);
    int zLen;
    expWrite_t e;
    zLen = sx + sy - 1;
    expErr = (sx == 0 || sy == 0 || zLen > 64) ? 1 : 0;
    if (expErr == 0) begin
      for (int z = 0; z < zLen; z++) begin
        e.z = z;
        e.reqLen = 2 + ((z == slowZ) ? slowExtra : 0);
        sbQ.push_back(e);
      end
    end
    sizex_i = ZW'(sx);
    sizey_i = ZW'(sy);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done_o && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_seen", int'(done_o), 1);
  endtask

  // End-of-run checks in the DONE cycle and the idle cycle that follows.
  task automatic finishRun(input string tag);
    checkOutput({tag, "_err"}, int'(err_o), expErr);
    checkOutput({tag, "_sb_empty"}, sbQ.size(), 0);
    checkOutput({tag, "_busy_in_done"}, int'(busy_o), 1);
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, int'(busy_o), 0);
    checkOutput({tag, "_idle_done"}, int'(done_o), 0);
  endtask

  initial begin
    int cyc;
    int doneBefore;
    int reqBefore;
    rst_a = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    sizex_i = '0;
    sizey_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_calc_req", int'(calc_req_o), 0);
    checkOutput("rst_zind", int'(zind_o), 0);
    checkOutput("rst_wr_en", int'(wr_en_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    checkOutput("rst_err", int'(err_o), 0);
    rst_a = 1'b0;
    @(negedge clk);

    // 3+2-1 = 4 entries with the fastest acknowledge, plus start latency.
    $display("[TB] basic run 3x2");
    applyStimulus(3, 2);
    checkOutput("lat_load_req", int'(calc_req_o), 0);
    checkOutput("lat_load_busy", int'(busy_o), 1);
    @(negedge clk);
    checkOutput("lat_first_req", int'(calc_req_o), 1);
    checkOutput("lat_first_zind", int'(zind_o), 0);
    waitDone(cyc);
    finishRun("basic");

    // Full-range run: 64 entries, last z is 63 with no wrap.
    $display("[TB] full range 32x33");
    applyStimulus(32, 33);
    waitDone(cyc);
    checkOutput("full_last_zind", int'(zind_o), 63);
    finishRun("full");

    // Zero size: no request, error flag, done two cycles after start.
    $display("[TB] zero size");
    reqBefore = totalReq;
    applyStimulus(0, 5);
    waitDone(cyc);
    checkOutput("zero_done_lat", cyc, 1);
    checkOutput("zero_no_req", totalReq - reqBefore, 0);
    finishRun("zero");

    // One entry past the index range is a configuration error too.
    $display("[TB] oversize 33x33");
    applyStimulus(33, 33);
    waitDone(cyc);
    finishRun("oversize");

    // Valid start clears the error; single-entry run.
    $display("[TB] single entry 1x1");
    applyStimulus(1, 1);
    checkOutput("err_cleared", int'(err_o), 0);
    waitDone(cyc);
    finishRun("single");

    // Slow acknowledge on z=1: eight WAIT cycles, index stable meanwhile.
    $display("[TB] slow ack");
    slowZ = 1;
    slowExtra = 7;
    applyStimulus(2, 2);
    waitDone(cyc);
    finishRun("slow");
    slowZ = -1;
    slowExtra = 0;

    // Abort in WAIT at z=2 together with the acknowledge.
    $display("[TB] abort in wait");
    doneBefore = doneCount;
    applyStimulus(4, 4);
    cyc = 0;
    while (!(calc_req_o && zind_o == ZW'(2)) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_reached_z2", int'(calc_req_o && zind_o == ZW'(2)), 1);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abort_busy", int'(busy_o), 0);
    checkOutput("abort_zind", int'(zind_o), 0);
    checkOutput("abort_req", int'(calc_req_o), 0);
    checkOutput("abort_wr", int'(wr_en_o), 0);
    repeat (2) @(negedge clk);
    checkOutput("abort_no_done", doneCount - doneBefore, 0);
    sbQ.delete();

    // Start mid-run must not recapture sizes or restart.
    $display("[TB] start while busy");
    applyStimulus(3, 3);
    repeat (5) @(negedge clk);
    sizex_i = ZW'(10);
    sizey_i = ZW'(10);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    waitDone(cyc);
    finishRun("busy_start");

    // Reset between clock edges mid-run forces reset values immediately.
    $display("[TB] async reset mid-run");
    applyStimulus(5, 5);
    repeat (6) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    checkOutput("arst_busy", int'(busy_o), 0);
    checkOutput("arst_zind", int'(zind_o), 0);
    checkOutput("arst_req", int'(calc_req_o), 0);
    checkOutput("arst_wr", int'(wr_en_o), 0);
    checkOutput("arst_done", int'(done_o), 0);
    @(negedge clk);
    rst_a = 1'b0;
    sbQ.delete();
    @(negedge clk);
    applyStimulus(2, 1);
    waitDone(cyc);
    finishRun("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
